apb4_master: RTL and testbench
==============================

Name: apb4_master

Overview:
- APB4 requester (initiator) that turns a simple valid/ready request/response channel into compliant APB4 SETUP/ACCESS transfers toward peripherals such as the timer, GPIO and UART slaves.
- Sits between a CPU-side or DMA-side bus adapter and the APB4 peripheral fabric.
- Handles one outstanding transfer at a time.
- Adds a bounded wait-state timeout so a hung slave cannot stall the requester.

Parameters:
- ADDR_WIDTH, 32: paddr and req_addr_i width.
- DATA_WIDTH, 32: pwdata/prdata width; must be 8, 16 or 32.
- TIMEOUT, 255: max ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  APB clock (pclk).
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_write_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_strb_i  in  DATA_WIDTH/8  write byte strobes.
- req_prot_i  in  3  pprot value.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and aborts.
- rsp_err_o  out  1  pslverr or timeout.
- rsp_timeout_o  out  1  set only on timeout abort.
- psel_o, penable_o, pwrite_o  out  1 each  APB4 controls.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB strobes.
- pprot_o  out  3  APB protection.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset: one clock and one reset, clk_i and rst_i. Reset is synchronous and active-high. On any clk_i edge with rst_i=1:
  - state=IDLE.
  - psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0.
  - paddr_o, pwdata_o, pstrb_o, pprot_o, rsp_rdata_o = 0.
  - Timeout counter = 0.
  - req_ready_o = 1 from the first cycle after reset.
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - req_ready_o=1 (combinational from state).
  - On req_valid_i&&req_ready_o, latch write/addr/wdata/prot. Latch strb when writing; force pstrb_o=0 for reads.
  - Go to SETUP.
- SETUP: psel_o=1, penable_o=0; unconditionally go to ACCESS next cycle.
- ACCESS: psel_o=1, penable_o=1. paddr/pwrite/pwdata/pstrb/pprot are stable from SETUP through the end of ACCESS.
  - pready_i=1: capture rsp_rdata_o=prdata_i on a read (0 on a write) and rsp_err_o=pslverr_i. Set rsp_timeout_o=0 and go to RESP. psel_o and penable_o drop at the same edge.
  - pready_i=0: increment the counter.
  - Timeout abort: if TIMEOUT!=0 and the counter equals TIMEOUT-1 while pready_i=0, abort. Set rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0 and go to RESP. The ACCESS phase therefore lasts exactly TIMEOUT cycles.
  - The counter clears on entering SETUP.
  - Counter width is $clog2(TIMEOUT+1), minimum 1.
- RESP:
  - rsp_valid_o=1, with rdata/err/timeout held stable until rsp_ready_i.
  - On rsp_ready_i go to IDLE; rsp_valid_o=0 the next cycle.
  - rsp_ready_i is ignored in all states other than RESP.
- Minimum transaction is 4 cycles, accept→SETUP→ACCESS(pready)→RESP(rsp_ready), so the next request is accepted on cycle 4.
- psel_o never asserts without a preceding SETUP cycle. penable_o is never high outside ACCESS.
- APB outputs hold their last values in IDLE/RESP; only psel/penable are 0 there.
- Inputs are not sampled except in IDLE (req), ACCESS (APB) and RESP (rsp_ready).
- Reset mid-transfer: next edge returns to IDLE, psel/penable drop, the pending response is discarded and no rsp_valid_o is produced.
- pslverr_i is sampled only with pready_i=1 in ACCESS.

Decomposition:
- Shared define file apb4_master_define.sv holds:
  - State encodings: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3.
  - APB4_PROT_WIDTH=3.
  - The default TIMEOUT.
- Optional sub-module apb4_master_tmo: saturating wait-state counter with clr/inc/expired. The FSM and datapath stay in one module.

Test Plan:
- Write addr=0x10, wdata=0xDEADBEEF, strb=4'hF, pready always 1 → SETUP then ACCESS with paddr=0x10, pwrite=1, pstrb=4'hF. rsp_valid_o on cycle 3 with err=0, rdata=0. req_ready_o returns high on cycle 4.
- Read addr=0x08, slave drives prdata=0x0000_00A5 after 3 wait states → ACCESS lasts 4 cycles, paddr stable, pstrb_o=0. rsp_rdata_o=0xA5, err=0.
- Read with pready=1 and pslverr=1 → rsp_err_o=1, rsp_timeout_o=0.
- TIMEOUT=4, pready held 0 → ACCESS exactly 4 cycles, then psel=0. rsp_err_o=1, rsp_timeout_o=1, rdata=0.
- rsp_ready_i held low 5 cycles, new req_valid_i asserted → req_ready_o stays 0, response stable. Accepted one cycle after the rsp handshake.
- rst_i pulsed during ACCESS → psel/penable 0 next cycle, no rsp_valid_o. A following read completes normally.

Source files
------------

// File: rtl/apb4_master_pkg.sv
// Shared definitions for the APB4 requester: FSM state encoding,
// protection field width and the default wait-state timeout.
package apb4_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int APB4_PROT_WIDTH = 3;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/apb4_master_tmo.sv
// Saturating wait-state counter for the ACCESS phase; 'expired' flags the
// last permitted ACCESS cycle so the FSM can abort a hung slave.
module apb4_master_tmo #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] MAX  = '1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // TIMEOUT of 0 disables the abort entirely; the counter just saturates.
    assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/apb4_master.sv
// APB4 requester: converts a valid/ready request channel into SETUP/ACCESS
// transfers, one at a time, and returns read data / error on a response channel.
module apb4_master
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [DATA_WIDTH-1:0]      req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]    req_strb_i,
    input  logic [APB4_PROT_WIDTH-1:0] req_prot_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic                       rsp_timeout_o,
    output logic                       psel_o,
    output logic                       penable_o,
    output logic                       pwrite_o,
    output logic [ADDR_WIDTH-1:0]      paddr_o,
    output logic [DATA_WIDTH-1:0]      pwdata_o,
    output logic [DATA_WIDTH/8-1:0]    pstrb_o,
    output logic [APB4_PROT_WIDTH-1:0] pprot_o,
    input  logic [DATA_WIDTH-1:0]      prdata_i,
    input  logic                       pready_i,
    input  logic                       pslverr_i
);

    apb_state_t state_q;
    apb_state_t state_d;
    logic       accept;
    logic       expired;

    assign accept = (state_q == IDLE) && req_valid_i;

    apb4_master_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (accept),
        .inc     ((state_q == ACCESS) && !pready_i),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = SETUP;
            end
            SETUP: begin
                psel_o  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i || expired) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            pprot_o       <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pwrite_o <= req_write_i;
                paddr_o  <= req_addr_i;
                pwdata_o <= req_wdata_i;
                pprot_o  <= req_prot_i;
                pstrb_o  <= req_write_i ? req_strb_i : '0;
            end
            // pready wins over the abort: a slave answering on the last cycle completes normally.
            if (state_q == ACCESS) begin
                if (pready_i) begin
                    rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                    rsp_err_o     <= pslverr_i;
                    rsp_timeout_o <= 1'b0;
                end else if (expired) begin
                    rsp_rdata_o   <= '0;
                    rsp_err_o     <= 1'b1;
                    rsp_timeout_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_master.sv
// Self-checking bench for apb4_master: directed vector table, reset corner
// cases and randomized transfers checked against a transaction-level model.
module tb_apb4_master;
    import apb4_master_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] prdata;
        bit          slverr;
        int          rsp_delay;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          tmo;
        int          len;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    apb4_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .req_prot_i    (req_prot),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .pprot_o       (pprot),
        .prdata_i      (prdata),
        .pready_i      (pready),
        .pslverr_i     (pslverr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Transaction-level expectation: slave answers after 'waits' low cycles
    // unless the timeout window (TMO ACCESS cycles) runs out first.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        bit   aborted;
        aborted = (TMO != 0) && (t.waits >= TMO);
        e.len   = aborted ? TMO : t.waits + 1;
        e.tmo   = aborted;
        e.err   = aborted || t.slverr;
        e.rdata = (aborted || t.write) ? 32'h0 : t.prdata;
        return e;
    endfunction

    task automatic check_apb_fields(input string tag, input txn_t t);
        check({tag, "_paddr"},  paddr,  t.addr);
        check({tag, "_pwrite"}, pwrite, t.write);
        check({tag, "_pwdata"}, pwdata, t.wdata);
        check({tag, "_pstrb"},  pstrb,  t.write ? t.strb : 4'h0);
        check({tag, "_pprot"},  pprot,  t.prot);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_txn(input txn_t t, input exp_t e);
        int n;
        check("idle_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = t.write;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        req_strb  = t.strb;
        req_prot  = t.prot;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        check("setup_psel", psel, 1'b1);
        check("setup_penable", penable, 1'b0);
        check("setup_req_ready", req_ready, 1'b0);
        check("setup_rsp_valid", rsp_valid, 1'b0);
        check_apb_fields("setup", t);
        n = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!(psel && penable)) break;
            n++;
            check_apb_fields("access", t);
            pready  = ((n - 1) == t.waits);
            prdata  = pready ? t.prdata : $urandom;
            pslverr = pready ? t.slverr : 1'($urandom);
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        check("access_len", n, e.len);
        check("resp_psel", psel, 1'b0);
        check("resp_penable", penable, 1'b0);
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_rdata", rsp_rdata, e.rdata);
        check("resp_err", rsp_err, e.err);
        check("resp_timeout", rsp_timeout, e.tmo);
        check_apb_fields("resp", t);
        for (int d = 0; d < t.rsp_delay; d++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_psel", psel, 1'b0);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_err", rsp_err, e.err);
            check("hold_timeout", rsp_timeout, e.tmo);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
        check("post_req_ready", req_ready, 1'b1);
    endtask

    vec_t vecs[6];

    initial begin
        txn_t t;
        exp_t e;

        vecs[0] = '{'{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0,       1'b0, 0},
                    '{32'h0,  1'b0, 1'b0, 1}};
        vecs[1] = '{'{1'b0, 32'h08, 32'h11111111, 4'hF, 3'd2, 3, 32'h000000A5, 1'b0, 5},
                    '{32'hA5, 1'b0, 1'b0, 4}};
        vecs[2] = '{'{1'b0, 32'h20, 32'h0,        4'h3, 3'd1, 0, 32'h00001234, 1'b1, 1},
                    '{32'h1234, 1'b1, 1'b0, 1}};
        vecs[3] = '{'{1'b0, 32'h30, 32'h0,        4'h0, 3'd0, 9, 32'hCAFEF00D, 1'b0, 1},
                    '{32'h0,  1'b1, 1'b1, 4}};
        vecs[4] = '{'{1'b1, 32'h44, 32'h55AA55AA, 4'h5, 3'd5, 2, 32'hFFFFFFFF, 1'b1, 2},
                    '{32'h0,  1'b1, 1'b0, 3}};
        vecs[5] = '{'{1'b0, 32'h4C, 32'h0,        4'hF, 3'd7, 4, 32'h87654321, 1'b0, 0},
                    '{32'h0,  1'b1, 1'b1, 4}};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pstrb", pstrb, 4'h0);
        check("rst_pprot", pprot, 3'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);

        for (int i = 0; i < 6; i++) run_txn(vecs[i].t, vecs[i].e);

        // Reset pulse in the middle of ACCESS discards the transfer.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h80;
        req_strb  = 4'h0;
        req_prot  = 3'd0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_access_penable", penable, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_psel", psel, 1'b0);
        check("mid_rst_penable", penable, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_paddr", paddr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_rsp", rsp_valid, 1'b0);
            check("mid_rst_no_psel", psel, 1'b0);
            @(negedge clk);
        end
        t = '{1'b0, 32'h84, 32'h0, 4'hF, 3'd3, 1, 32'h0BADF00D, 1'b0, 0};
        run_txn(t, model(t));

        for (int i = 0; i < 40; i++) begin
            t.write     = 1'($urandom);
            t.addr      = $urandom & 32'hFFFF_FFFC;
            t.wdata     = $urandom;
            t.strb      = 4'($urandom);
            t.prot      = 3'($urandom);
            t.waits     = $urandom_range(0, 6);
            t.prdata    = $urandom;
            t.slverr    = 1'($urandom_range(0, 3) == 0);
            t.rsp_delay = $urandom_range(0, 2);
            run_txn(t, model(t));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
